// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encodings and sizing helpers for the PISO serializer
// Frame length depends on PISO_SERIALIZER_PARITY_EN.
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bits per frame: data bits, plus one parity bit when parity is built in.
    function automatic int frame_bits(input int width);
`ifdef PISO_SERIALIZER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_period_counter.sv
// rtl/bit_period_counter.sv - mod-CLKS_PER_BIT counter, bit_tick_o on the last cycle of each bit
module bit_period_counter
    import piso_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic bit_tick_o
);

    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    assign bit_tick_o = (div_cnt_q == LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        if (clear_i || bit_tick_o) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with valid/ready load
// Optional even-parity bit after the data bits when PISO_SERIALIZER_PARITY_EN is defined.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH        = 8,
    parameter int   CLKS_PER_BIT = 1,
    parameter int   MSB_FIRST    = 0,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic             clock_pos,
    input  logic             reset_pos,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             frame_active,
    output logic             done_pulse
);

    localparam int FB  = frame_bits(WIDTH);
    localparam int BCW = cnt_w(WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(FB - 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("piso_serializer: WIDTH must be at least 1");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $error("piso_serializer: CLKS_PER_BIT must be at least 1");
    end

    state_e         state_q, state_d;
    logic [FB-1:0]  shreg_q, shreg_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic           serial_q, serial_d;
    logic           done_q, done_d;
    logic [FB-1:0]  frame_word;
    logic           bit_tick;

    bit_period_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_period_counter (
        .clk_i      (clock_pos),
        .rst_i      (reset_pos),
        .clear_i    (state_q == ST_IDLE),
        .bit_tick_o (bit_tick)
    );

    // The bit on the leading edge of the register is always the one on the line.
    function automatic logic lead_bit(input logic [FB-1:0] w);
        return (MSB_FIRST != 0) ? w[FB-1] : w[0];
    endfunction

    always_comb begin
`ifdef PISO_SERIALIZER_PARITY_EN
        frame_word = (MSB_FIRST != 0) ? {data_in, ^data_in} : {^data_in, data_in};
`else
        frame_word = data_in;
`endif
    end

    always_ff @(posedge clock_pos) begin
        if (reset_pos) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            serial_q  <= IDLE_LEVEL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        serial_d  = serial_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                serial_d  = IDLE_LEVEL;
                bit_cnt_d = '0;
                if (load_valid) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = frame_word;
                    serial_d = lead_bit(frame_word);
                end
            end
            ST_SHIFT: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d  = ST_IDLE;
                        serial_d = IDLE_LEVEL;
                        done_d   = 1'b1;
                    end else begin
                        // Rotate rather than shift so every register bit stays live.
                        shreg_d = (MSB_FIRST != 0)
                                ? ((shreg_q << 1) | (shreg_q >> (FB - 1)))
                                : ((shreg_q >> 1) | (shreg_q << (FB - 1)));
                        serial_d  = lead_bit(shreg_d);
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_ready   = (state_q == ST_IDLE);
        frame_active = (state_q == ST_SHIFT);
        serial_out   = serial_q;
        done_pulse   = done_q;
    end

endmodule
